branch_cmp_scheduler: RTL and testbench

- Shares the single branch comparator among the 4 issue lanes of the superscalar pipeline.
- Accepts one decoded bundle and drives the comparator with one lane's operands per cycle, oldest lane (lane 0) first.
- Stops at the first taken branch, then reports the redirect PC and a kill mask for the younger lanes.
- Sits between decode/issue and the front-end redirect logic; stalls issue while busy.

---
 rtl/branch_cmp_scheduler_pkg.sv | 22 ++
 rtl/branch_cmp_scheduler_lowest_set_picker.sv | 23 ++
 rtl/branch_cmp_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_branch_cmp_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_cmp_scheduler_pkg.sv
// Shared types and constants for the branch comparator scheduler.
// Holds the scheduler state encoding, compare pattern codes and default sizes.
package branch_cmp_scheduler_pkg;

   localparam int unsigned DEF_LANES = 4;
   localparam int unsigned DEF_XLEN  = 32;
   localparam int unsigned RT_W      = 5;
   localparam int unsigned PAT_W     = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [PAT_W-1:0] CMP_EQ  = 3'b000;
   localparam logic [PAT_W-1:0] CMP_NE  = 3'b001;
   localparam logic [PAT_W-1:0] CMP_GT  = 3'b010;
   localparam logic [PAT_W-1:0] CMP_LE  = 3'b011;
   localparam logic [PAT_W-1:0] CMP_RTZ = 3'b100;

endpackage

// File: rtl/branch_cmp_scheduler_lowest_set_picker.sv
// Priority encoder: index of the lowest set request bit, plus a found flag.
module lowest_set_picker #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx,
   output logic          found
);

   // Scan from the top so the lowest set bit is the last one written.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = IW'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/branch_cmp_scheduler.sv
// Time-shares one branch comparator across the issue lanes of a bundle, oldest
// lane first, stopping at the first taken branch and reporting redirect/kill.
module branch_cmp_scheduler
   import branch_cmp_scheduler_pkg::*;
#(
   parameter int unsigned LANES = DEF_LANES,
   parameter int unsigned XLEN  = DEF_XLEN,
   parameter int unsigned IW    = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    bundle_valid,
   output logic                    bundle_ready,
   input  logic [LANES-1:0]        lane_valid,
   input  logic [LANES-1:0]        lane_is_branch,
   input  logic [LANES*XLEN-1:0]   lane_a,
   input  logic [LANES*XLEN-1:0]   lane_b,
   input  logic [LANES*RT_W-1:0]   lane_rt,
   input  logic [LANES*PAT_W-1:0]  lane_pattern,
   input  logic [LANES*XLEN-1:0]   lane_target,
   output logic [XLEN-1:0]         cmp_a,
   output logic [XLEN-1:0]         cmp_b,
   output logic [RT_W-1:0]         cmp_rt,
   output logic [PAT_W-1:0]        cmp_pattern,
   input  logic                    cmp_equal,
   output logic                    result_valid,
   input  logic                    result_ready,
   output logic                    taken,
   output logic [IW-1:0]           taken_lane,
   output logic [XLEN-1:0]         redirect_pc,
   output logic [LANES-1:0]        kill_mask
);

   state_t             state, state_nxt;
   logic [LANES-1:0]   pending, pending_nxt;
   logic [LANES-1:0]   valid_q;
   logic [IW-1:0]      sel_q, sel_nxt;
   logic               load;

   logic [XLEN-1:0]    a_q   [LANES];
   logic [XLEN-1:0]    b_q   [LANES];
   logic [XLEN-1:0]    tgt_q [LANES];
   logic [RT_W-1:0]    rt_q  [LANES];
   logic [PAT_W-1:0]   pat_q [LANES];

   logic [XLEN-1:0]    in_a   [LANES];
   logic [XLEN-1:0]    in_b   [LANES];
   logic [XLEN-1:0]    in_tgt [LANES];
   logic [RT_W-1:0]    in_rt  [LANES];
   logic [PAT_W-1:0]   in_pat [LANES];

   logic               taken_nxt;
   logic [IW-1:0]      taken_lane_nxt;
   logic [XLEN-1:0]    redirect_nxt;
   logic [LANES-1:0]   kill_nxt;
   logic [LANES-1:0]   kill_above;
   logic [LANES-1:0]   sel_onehot;

   logic [XLEN-1:0]    cmp_a_nxt, cmp_b_nxt;
   logic [RT_W-1:0]    cmp_rt_nxt;
   logic [PAT_W-1:0]   cmp_pat_nxt;

   logic [IW-1:0]      pick_idx;
   logic               pick_found;

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         in_a[i]   = lane_a[i*XLEN +: XLEN];
         in_b[i]   = lane_b[i*XLEN +: XLEN];
         in_tgt[i] = lane_target[i*XLEN +: XLEN];
         in_rt[i]  = lane_rt[i*RT_W +: RT_W];
         in_pat[i] = lane_pattern[i*PAT_W +: PAT_W];
      end
   end

   // Valid lanes younger than the lane currently on the comparator.
   always_comb begin
      sel_onehot = LANES'(1) << sel_q;
      kill_above = '0;
      for (int i = 0; i < LANES; i++) begin
         kill_above[i] = valid_q[i] & (IW'(i) > sel_q);
      end
   end

   always_comb begin
      state_nxt      = state;
      pending_nxt    = pending;
      load           = 1'b0;
      taken_nxt      = taken;
      taken_lane_nxt = taken_lane;
      redirect_nxt   = redirect_pc;
      kill_nxt       = kill_mask;
      case (state)
         ST_IDLE: begin
            if (bundle_valid) begin
               load           = 1'b1;
               pending_nxt    = lane_valid & lane_is_branch;
               taken_nxt      = 1'b0;
               taken_lane_nxt = '0;
               redirect_nxt   = '0;
               kill_nxt       = '0;
               state_nxt      = (pending_nxt == '0) ? ST_DONE : ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (cmp_equal) begin
               taken_nxt      = 1'b1;
               taken_lane_nxt = sel_q;
               redirect_nxt   = tgt_q[sel_q];
               kill_nxt       = kill_above;
               state_nxt      = ST_DONE;
            end else begin
               pending_nxt = pending & ~sel_onehot;
               if (pending_nxt == '0) begin
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (result_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (flush) begin
         state_nxt   = ST_IDLE;
         pending_nxt = '0;
         load        = 1'b0;
         taken_nxt   = 1'b0;
         kill_nxt    = '0;
      end
   end

   lowest_set_picker #(.N(LANES), .IW(IW)) u_pick (
      .req   (pending_nxt),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // Preload the comparator registers with the lane that will be scanned next.
   always_comb begin
      sel_nxt     = sel_q;
      cmp_a_nxt   = cmp_a;
      cmp_b_nxt   = cmp_b;
      cmp_rt_nxt  = cmp_rt;
      cmp_pat_nxt = cmp_pattern;
      if (state_nxt == ST_SCAN && pick_found) begin
         sel_nxt = pick_idx;
         if (state == ST_IDLE) begin
            cmp_a_nxt   = in_a[pick_idx];
            cmp_b_nxt   = in_b[pick_idx];
            cmp_rt_nxt  = in_rt[pick_idx];
            cmp_pat_nxt = in_pat[pick_idx];
         end else begin
            cmp_a_nxt   = a_q[pick_idx];
            cmp_b_nxt   = b_q[pick_idx];
            cmp_rt_nxt  = rt_q[pick_idx];
            cmp_pat_nxt = pat_q[pick_idx];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending      <= '0;
         valid_q      <= '0;
         sel_q        <= '0;
         bundle_ready <= 1'b1;
         result_valid <= 1'b0;
         taken        <= 1'b0;
         taken_lane   <= '0;
         redirect_pc  <= '0;
         kill_mask    <= '0;
         cmp_a        <= '0;
         cmp_b        <= '0;
         cmp_rt       <= '0;
         cmp_pattern  <= '0;
      end else begin
         pending      <= pending_nxt;
         if (load) begin
            valid_q <= lane_valid;
         end
         sel_q        <= sel_nxt;
         bundle_ready <= (state_nxt == ST_IDLE);
         result_valid <= (state_nxt == ST_DONE);
         taken        <= taken_nxt;
         taken_lane   <= taken_lane_nxt;
         redirect_pc  <= redirect_nxt;
         kill_mask    <= kill_nxt;
         cmp_a        <= cmp_a_nxt;
         cmp_b        <= cmp_b_nxt;
         cmp_rt       <= cmp_rt_nxt;
         cmp_pattern  <= cmp_pat_nxt;
      end
   end

   // Lane operand storage needs no reset: it is only read after a load.
   always_ff @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < LANES; i++) begin
            a_q[i]   <= in_a[i];
            b_q[i]   <= in_b[i];
            tgt_q[i] <= in_tgt[i];
            rt_q[i]  <= in_rt[i];
            pat_q[i] <= in_pat[i];
         end
      end
   end

endmodule

// File: tb/tb_branch_cmp_scheduler.sv
// Bench for branch_cmp_scheduler: behavioural comparator plus a lane-walk
// reference model, directed scenarios followed by randomized bundles.
module tb_branch_cmp_scheduler;
   import branch_cmp_scheduler_pkg::*;

   localparam int unsigned L = 4;
   localparam int unsigned X = 32;

   logic            clk;
   logic            reset;
   logic            flush;
   logic            bundle_valid;
   logic            bundle_ready;
   logic [L-1:0]    lane_valid;
   logic [L-1:0]    lane_is_branch;
   logic [L*X-1:0]  lane_a;
   logic [L*X-1:0]  lane_b;
   logic [L*5-1:0]  lane_rt;
   logic [L*3-1:0]  lane_pattern;
   logic [L*X-1:0]  lane_target;
   logic [X-1:0]    cmp_a;
   logic [X-1:0]    cmp_b;
   logic [4:0]      cmp_rt;
   logic [2:0]      cmp_pattern;
   logic            cmp_equal;
   logic            result_valid;
   logic            result_ready;
   logic            taken;
   logic [1:0]      taken_lane;
   logic [X-1:0]    redirect_pc;
   logic [L-1:0]    kill_mask;

   int vectors = 0;
   int errs    = 0;

   // Current bundle as seen by the model.
   logic [L-1:0]    bv, bb;
   logic [X-1:0]    ba  [L];
   logic [X-1:0]    bbv [L];
   logic [X-1:0]    bt  [L];
   logic [4:0]      brt [L];
   logic [2:0]      bp  [L];

   int              exp_lanes[$];
   logic            exp_taken;
   logic [1:0]      exp_lane;
   logic [X-1:0]    exp_pc;
   logic [L-1:0]    exp_kill;

   branch_cmp_scheduler dut (
      .clk            (clk),
      .reset          (reset),
      .flush          (flush),
      .bundle_valid   (bundle_valid),
      .bundle_ready   (bundle_ready),
      .lane_valid     (lane_valid),
      .lane_is_branch (lane_is_branch),
      .lane_a         (lane_a),
      .lane_b         (lane_b),
      .lane_rt        (lane_rt),
      .lane_pattern   (lane_pattern),
      .lane_target    (lane_target),
      .cmp_a          (cmp_a),
      .cmp_b          (cmp_b),
      .cmp_rt         (cmp_rt),
      .cmp_pattern    (cmp_pattern),
      .cmp_equal      (cmp_equal),
      .result_valid   (result_valid),
      .result_ready   (result_ready),
      .taken          (taken),
      .taken_lane     (taken_lane),
      .redirect_pc    (redirect_pc),
      .kill_mask      (kill_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic ref_cmp(input logic [X-1:0] a, input logic [X-1:0] b,
                                    input logic [4:0] rt, input logic [2:0] pat);
      case (pat)
         CMP_EQ:  return a == b;
         CMP_NE:  return a != b;
         CMP_GT:  return $signed(a) > $signed(b);
         CMP_LE:  return $signed(a) <= $signed(b);
         CMP_RTZ: return rt[0] ? ($signed(a) >= 0) : ($signed(a) < 0);
         default: return 1'b0;
      endcase
   endfunction

   // The shared comparator sitting on the cmp_* ports.
   always_comb cmp_equal = ref_cmp(cmp_a, cmp_b, cmp_rt, cmp_pattern);

   task automatic drive_bundle();
      lane_valid     = bv;
      lane_is_branch = bb;
      for (int i = 0; i < L; i++) begin
         lane_a[i*X +: X]      = ba[i];
         lane_b[i*X +: X]      = bbv[i];
         lane_target[i*X +: X] = bt[i];
         lane_rt[i*5 +: 5]     = brt[i];
         lane_pattern[i*3 +: 3] = bp[i];
      end
   endtask

   // Walk lanes oldest first; stop at the first taken branch.
   task automatic build_expect();
      exp_lanes.delete();
      exp_taken = 1'b0;
      exp_lane  = 2'd0;
      exp_pc    = '0;
      exp_kill  = '0;
      for (int i = 0; i < L; i++) begin
         if (bv[i] && bb[i] && !exp_taken) begin
            exp_lanes.push_back(i);
            if (ref_cmp(ba[i], bbv[i], brt[i], bp[i])) begin
               exp_taken = 1'b1;
               exp_lane  = 2'(i);
               exp_pc    = bt[i];
               for (int j = i + 1; j < L; j++) exp_kill[j] = bv[j];
            end
         end
      end
   endtask

   task automatic rand_bundle();
      bv = 4'($urandom);
      bb = 4'($urandom);
      for (int i = 0; i < L; i++) begin
         ba[i]  = $urandom;
         bbv[i] = ($urandom_range(0, 1) == 1) ? ba[i] : $urandom;
         bt[i]  = $urandom;
         brt[i] = 5'($urandom);
         bp[i]  = 3'($urandom_range(0, 4));
      end
   endtask

   task automatic run_bundle(input int hold, input string name);
      int  cyc;
      bit  got;
      int  li;
      build_expect();
      @(negedge clk);
      vectors++;
      if (bundle_ready !== 1'b1) begin
         errs++;
         $display("FAIL %s accept: bundle_ready=%b expected 1", name, bundle_ready);
      end
      drive_bundle();
      bundle_valid = 1'b1;
      @(negedge clk);
      bundle_valid = 1'b0;
      got = 1'b0;
      cyc = 1;
      while (!got && cyc <= 8) begin
         if (result_valid === 1'b1) begin
            got = 1'b1;
         end else begin
            vectors++;
            if (cyc - 1 >= exp_lanes.size()) begin
               errs++;
               $display("FAIL %s scan: extra compare cycle %0d, expected %0d compares",
                        name, cyc, exp_lanes.size());
            end else begin
               li = exp_lanes[cyc-1];
               if (cmp_a !== ba[li] || cmp_b !== bbv[li] || cmp_rt !== brt[li] ||
                   cmp_pattern !== bp[li] || bundle_ready !== 1'b0) begin
                  errs++;
                  $display("FAIL %s scan lane%0d: a=%h b=%h rt=%h p=%h rdy=%b expected a=%h b=%h rt=%h p=%h rdy=0",
                           name, li, cmp_a, cmp_b, cmp_rt, cmp_pattern, bundle_ready,
                           ba[li], bbv[li], brt[li], bp[li]);
               end
            end
            @(negedge clk);
            cyc++;
         end
      end
      vectors++;
      if (!got) begin
         errs++;
         $display("FAIL %s timeout: result_valid never rose, expected latency %0d",
                  name, 1 + exp_lanes.size());
         return;
      end else if (cyc != 1 + exp_lanes.size()) begin
         errs++;
         $display("FAIL %s latency: got %0d cycles expected %0d", name, cyc, 1 + exp_lanes.size());
      end
      for (int h = 0; h <= hold; h++) begin
         vectors++;
         if (result_valid !== 1'b1 || bundle_ready !== 1'b0 || taken !== exp_taken ||
             kill_mask !== exp_kill || (exp_taken && (taken_lane !== exp_lane || redirect_pc !== exp_pc))) begin
            errs++;
            $display("FAIL %s result h%0d: v=%b rdy=%b tk=%b ln=%0d pc=%h kill=%b expected v=1 rdy=0 tk=%b ln=%0d pc=%h kill=%b",
                     name, h, result_valid, bundle_ready, taken, taken_lane, redirect_pc, kill_mask,
                     exp_taken, exp_lane, exp_pc, exp_kill);
         end
         result_ready = (h == hold);
         @(negedge clk);
      end
      result_ready = 1'b0;
      vectors++;
      if (bundle_ready !== 1'b1 || result_valid !== 1'b0) begin
         errs++;
         $display("FAIL %s release: rdy=%b v=%b expected rdy=1 v=0", name, bundle_ready, result_valid);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; bundle_valid = 1'b0; result_ready = 1'b0;
      rand_bundle();
      drive_bundle();
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (bundle_ready !== 1'b1 || result_valid !== 1'b0 || taken !== 1'b0 || taken_lane !== 2'd0 ||
          redirect_pc !== '0 || kill_mask !== '0 || cmp_a !== '0 || cmp_b !== '0 ||
          cmp_rt !== '0 || cmp_pattern !== '0) begin
         errs++;
         $display("FAIL reset values: rdy=%b v=%b tk=%b ln=%0d pc=%h kill=%b a=%h b=%h rt=%h p=%h expected 1/0/0/0/0/0/0/0/0/0",
                  bundle_ready, result_valid, taken, taken_lane, redirect_pc, kill_mask,
                  cmp_a, cmp_b, cmp_rt, cmp_pattern);
      end
      reset = 1'b0;
   endtask

   task automatic test_no_branch();
      rand_bundle();
      bv = 4'b1111; bb = 4'b0000;
      run_bundle(0, "no_branch");
   endtask

   task automatic test_oldest_taken();
      rand_bundle();
      bv = 4'b1111; bb = 4'b0101;
      ba[0] = 32'd5; bbv[0] = 32'd5; bp[0] = CMP_EQ; bt[0] = 32'h400;
      ba[2] = 32'd3; bbv[2] = 32'd3; bp[2] = CMP_EQ;
      run_bundle(0, "oldest_taken");
   endtask

   task automatic test_skip_younger();
      rand_bundle();
      bv = 4'b1111; bb = 4'b1010;
      ba[1] = 32'd7; bbv[1] = 32'd7; bp[1] = CMP_NE;
      ba[3] = 32'd9; bbv[3] = 32'd9; bp[3] = CMP_EQ; bt[3] = 32'h800;
      run_bundle(0, "skip_younger");
   endtask

   task automatic test_backpressure();
      rand_bundle();
      bv = 4'b1111; bb = 4'b0010;
      ba[1] = 32'd1; bbv[1] = 32'd1; bp[1] = CMP_EQ;
      run_bundle(4, "backpressure");
   endtask

   task automatic test_flush();
      rand_bundle();
      bv = 4'b1111; bb = 4'b1111;
      for (int i = 0; i < L; i++) begin
         ba[i] = 32'(i); bbv[i] = 32'(i + 100); bp[i] = CMP_EQ;
      end
      @(negedge clk);
      drive_bundle();
      bundle_valid = 1'b1;
      @(negedge clk);
      bundle_valid = 1'b0;
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      vectors++;
      if (bundle_ready !== 1'b1 || result_valid !== 1'b0) begin
         errs++;
         $display("FAIL flush_scan: rdy=%b v=%b expected rdy=1 v=0", bundle_ready, result_valid);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         vectors++;
         if (result_valid !== 1'b0) begin
            errs++;
            $display("FAIL flush_quiet c%0d: result_valid=%b expected 0", c, result_valid);
         end
      end
      // Flush together with an offered bundle in IDLE must drop the bundle.
      bundle_valid = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      bundle_valid = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      vectors++;
      if (result_valid !== 1'b0 || bundle_ready !== 1'b1) begin
         errs++;
         $display("FAIL flush_idle: v=%b rdy=%b expected v=0 rdy=1", result_valid, bundle_ready);
      end
      rand_bundle();
      run_bundle(0, "after_flush");
   endtask

   task automatic test_async_reset();
      int c;
      rand_bundle();
      bv = 4'b0111; bb = 4'b0001;
      ba[0] = 32'd2; bbv[0] = 32'd2; bp[0] = CMP_EQ; bt[0] = 32'h1234;
      @(negedge clk);
      drive_bundle();
      bundle_valid = 1'b1;
      @(negedge clk);
      bundle_valid = 1'b0;
      c = 0;
      while (result_valid !== 1'b1 && c < 8) begin
         @(negedge clk);
         c++;
      end
      vectors++;
      if (result_valid !== 1'b1 || taken !== 1'b1) begin
         errs++;
         $display("FAIL areset_setup: v=%b tk=%b expected v=1 tk=1", result_valid, taken);
      end
      #1 reset = 1'b1;
      #1;
      vectors++;
      if (result_valid !== 1'b0 || taken !== 1'b0 || kill_mask !== '0 || bundle_ready !== 1'b1 ||
          redirect_pc !== '0 || cmp_a !== '0) begin
         errs++;
         $display("FAIL areset_async: v=%b tk=%b kill=%b rdy=%b pc=%h a=%h expected 0/0/0/1/0/0",
                  result_valid, taken, kill_mask, bundle_ready, redirect_pc, cmp_a);
      end
      #1 reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (bundle_ready !== 1'b1 || result_valid !== 1'b0) begin
         errs++;
         $display("FAIL areset_release: rdy=%b v=%b expected rdy=1 v=0", bundle_ready, result_valid);
      end
      rand_bundle();
      run_bundle(1, "after_areset");
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 4; n++) begin
         rand_bundle();
         bv = 4'b1111; bb = 4'b1111;
         run_bundle(0, "back_to_back");
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         rand_bundle();
         run_bundle($urandom_range(0, 2), "random");
      end
   endtask

   initial begin
      test_reset();
      test_no_branch();
      test_oldest_taken();
      test_skip_younger();
      test_backpressure();
      test_flush();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
